piso_serializer: RTL and testbench

- Parallel-in/serial-out transmitter: accepts a SIZE-bit word over a valid/ready handshake and shifts it out one bit per clk.
- Its serial stream, with frame strobes, drives the serial-in end of the team's SISO/SIPO shift-register chains.
- Sits between a word-wide producer and a single-wire serial link.

---
 rtl/piso_pkg.sv | 12 +
 rtl/d_ff.sv | 11 +
 rtl/piso_shift_reg.sv | 21 ++
 rtl/piso_serializer.sv | 80 ++++++++
 tb/tb_piso_serializer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helpers for the PISO serializer (PISO_PARITY_EN adds a parity bit per frame)
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t;
  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction
`ifdef PISO_PARITY_EN
  localparam int PAR_EXT = 1;
`else
  localparam int PAR_EXT = 0;
`endif
endpackage

// File: rtl/d_ff.sv
// d_ff: W-bit D flip-flop with synchronous active-high reset
module d_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk) o_q <= rst ? '0 : i_d;
endmodule

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable shift register; o_next is the bit that becomes head after the next shift
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_shift,
  input  logic [SIZE-1:0] i_d,
  output logic            o_next
);
  logic [SIZE-1:0] w_q, w_d;
  assign w_d = i_load ? i_d
             : i_shift ? (MSB_FIRST != 0 ? {w_q[SIZE-2:0], 1'b0} : {1'b0, w_q[SIZE-1:1]})
             : w_q;
  assign o_next = MSB_FIRST != 0 ? w_q[SIZE-2] : w_q[1];
  d_ff #(.W(SIZE)) u_ff (.clk(clk), .rst(rst), .i_d(w_d), .o_q(w_q));
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out transmitter with frame strobes
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int MSB_FIRST = 0,
  parameter int IDLE_GAP  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_valid,
  output logic            load_ready,
  output logic            ser_out,
  output logic            ser_valid,
  output logic            frame_start,
  output logic            frame_end,
  output logic            busy
);
  localparam int CW = cnt_w(SIZE);
  localparam logic [CW-1:0] CNT_INIT = CW'(SIZE - 1 + PAR_EXT);
  piso_state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0] r_gap, w_gap_nx;
  logic w_last, w_acc, w_more, w_head, w_next, w_bit;
  // r_cnt counts bits still to send after the one currently on ser_out
  assign w_last     = r_state == SHIFT && r_cnt == '0;
  assign w_more     = r_state == SHIFT && r_cnt != '0;
  assign load_ready = !rst && (r_state == IDLE || (IDLE_GAP == 0 && w_last));
  assign w_acc      = load_valid && load_ready;
  assign w_head     = MSB_FIRST != 0 ? data_in[SIZE-1] : data_in[0];
  assign busy       = r_state != IDLE;
`ifdef PISO_PARITY_EN
  logic r_par;
  always_ff @(posedge clk) r_par <= rst ? 1'b0 : w_acc ? ^data_in : r_par;
  assign w_bit = r_cnt == CW'(1) ? r_par : w_next;
`else
  assign w_bit = w_next;
`endif
  piso_shift_reg #(.SIZE(SIZE), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk(clk), .rst(rst), .i_load(w_acc), .i_shift(w_more), .i_d(data_in), .o_next(w_next)
  );
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_gap_nx   = r_gap;
    if (w_acc) begin
      w_state_nx = SHIFT;
      w_cnt_nx   = CNT_INIT;
    end else if (w_more) begin
      w_cnt_nx = r_cnt - 1'b1;
    end else if (w_last) begin
      w_state_nx = IDLE_GAP > 0 ? GAP : IDLE;
      w_gap_nx   = 4'(IDLE_GAP - 1);
    end else if (r_state == GAP) begin
      w_state_nx = r_gap == '0 ? IDLE : GAP;
      w_gap_nx   = r_gap == '0 ? 4'd0 : r_gap - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gap       <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_gap       <= w_gap_nx;
      ser_out     <= w_acc ? w_head : w_more ? w_bit : 1'b0;
      ser_valid   <= w_state_nx == SHIFT;
      frame_start <= w_acc;
      frame_end   <= w_state_nx == SHIFT && w_cnt_nx == '0;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of three serializer configurations (LSB/no gap, MSB-first, gap of 3)
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [3:0] d0 = 0, d1 = 0, d2 = 0;
  logic v0 = 0, v1 = 0, v2 = 0;
  logic r0, so0, sv0, fs0, fe0, b0;
  logic r1, so1, sv1, fs1, fe1, b1;
  logic r2, so2, sv2, fs2, fe2, b2;
  int n_cmp = 0, n_err = 0;

  piso_serializer #(.SIZE(4), .MSB_FIRST(0), .IDLE_GAP(0)) u0 (
    .clk(clk), .rst(rst), .data_in(d0), .load_valid(v0), .load_ready(r0), .ser_out(so0),
    .ser_valid(sv0), .frame_start(fs0), .frame_end(fe0), .busy(b0));
  piso_serializer #(.SIZE(4), .MSB_FIRST(1), .IDLE_GAP(0)) u1 (
    .clk(clk), .rst(rst), .data_in(d1), .load_valid(v1), .load_ready(r1), .ser_out(so1),
    .ser_valid(sv1), .frame_start(fs1), .frame_end(fe1), .busy(b1));
  piso_serializer #(.SIZE(4), .MSB_FIRST(0), .IDLE_GAP(3)) u2 (
    .clk(clk), .rst(rst), .data_in(d2), .load_valid(v2), .load_ready(r2), .ser_out(so2),
    .ser_valid(sv2), .frame_start(fs2), .frame_end(fe2), .busy(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected bit k of a frame: data bits in wire order, then even parity
  function automatic logic fb(input logic [3:0] w, input int k, input bit msb);
    return k < 4 ? w[msb ? 3 - k : k] : ^w;
  endfunction

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", r0, 0);
    chk("rst_sout", so0, 0);
    chk("rst_svalid", sv0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_fs_fe", {fs0, fe0}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", r0, 1);
    chk("idle_busy", b0, 0);
    // single word 1011, LSB first
    d0 = 4'b1011; v0 = 1;
    @(negedge clk);
    v0 = 0; d0 = 4'h0;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("one_bit%0d", k), so0, fb(4'b1011, k, 0));
      chk($sformatf("one_sv%0d", k), sv0, 1);
      chk($sformatf("one_fs%0d", k), fs0, k == 0);
      chk($sformatf("one_fe%0d", k), fe0, k == FL - 1);
      chk($sformatf("one_busy%0d", k), b0, 1);
      chk($sformatf("one_rdy%0d", k), r0, k == FL - 1);
      @(negedge clk);
    end
    chk("one_after_sv", sv0, 0);
    chk("one_after_busy", b0, 0);
    chk("one_after_rdy", r0, 1);
    // back-to-back A then 5
    v0 = 1; d0 = 4'hA;
    @(negedge clk);
    d0 = 4'h5;
    for (int k = 0; k < 2 * FL; k++) begin
      chk($sformatf("b2b_bit%0d", k), so0, fb(k < FL ? 4'hA : 4'h5, k % FL, 0));
      chk($sformatf("b2b_sv%0d", k), sv0, 1);
      chk($sformatf("b2b_fs%0d", k), fs0, k % FL == 0);
      chk($sformatf("b2b_fe%0d", k), fe0, k % FL == FL - 1);
      chk($sformatf("b2b_rdy%0d", k), r0, k % FL == FL - 1);
      if (k == FL) v0 = 0;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_sv%0d", i), sv0, 0);
      chk($sformatf("hold_sout%0d", i), so0, 0);
      chk($sformatf("hold_busy%0d", i), b0, 0);
      @(negedge clk);
    end
    // gap enforcement on u2
    v2 = 1; d2 = 4'hA;
    @(negedge clk);
    d2 = 4'h5;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("gap1_bit%0d", k), so2, fb(4'hA, k, 0));
      chk($sformatf("gap1_fe%0d", k), fe2, k == FL - 1);
      chk($sformatf("gap1_rdy%0d", k), r2, 0);
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("gap_sv%0d", g), sv2, 0);
      chk($sformatf("gap_sout%0d", g), so2, 0);
      chk($sformatf("gap_rdy%0d", g), r2, 0);
      chk($sformatf("gap_busy%0d", g), b2, 1);
      @(negedge clk);
    end
    chk("gap_idle_rdy", r2, 1);
    chk("gap_idle_sv", sv2, 0);
    @(negedge clk);
    v2 = 0;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("gap2_bit%0d", k), so2, fb(4'h5, k, 0));
      chk($sformatf("gap2_fs%0d", k), fs2, k == 0);
      chk($sformatf("gap2_sv%0d", k), sv2, 1);
      @(negedge clk);
    end
    chk("gap2_after_sv", sv2, 0);
    // MSB first on u1
    v1 = 1; d1 = 4'b1000;
    @(negedge clk);
    v1 = 0;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("msb_bit%0d", k), so1, fb(4'b1000, k, 1));
      chk($sformatf("msb_fs%0d", k), fs1, k == 0);
      chk($sformatf("msb_fe%0d", k), fe1, k == FL - 1);
      @(negedge clk);
    end
    // reset during the second bit of F
    v0 = 1; d0 = 4'hF;
    @(negedge clk);
    v0 = 0;
    chk("mid_bit0", so0, 1);
    chk("mid_fs0", fs0, 1);
    @(negedge clk);
    chk("mid_bit1", so0, 1);
    chk("mid_sv1", sv0, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_out", {so0, sv0, fs0, fe0}, 0);
    chk("mid_rst_busy", b0, 0);
    chk("mid_rst_rdy", r0, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_rdy", r0, 1);
    chk("post_rst_busy", b0, 0);
    chk("post_rst_fe", fe0, 0);
    v0 = 1; d0 = 4'b0110;
    @(negedge clk);
    v0 = 0;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("rec_bit%0d", k), so0, fb(4'b0110, k, 0));
      chk($sformatf("rec_fe%0d", k), fe0, k == FL - 1);
      @(negedge clk);
    end
    // 0111: with parity the trailer bit is 1
    v0 = 1; d0 = 4'b0111;
    @(negedge clk);
    v0 = 0;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("par_bit%0d", k), so0, fb(4'b0111, k, 0));
      chk($sformatf("par_fe%0d", k), fe0, k == FL - 1);
      chk($sformatf("par_sv%0d", k), sv0, 1);
      @(negedge clk);
    end
    chk("par_after_sv", sv0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
